openofdm_tx_psdu_framer: RTL and testbench

Transmit-side counterpart of the receiver's byte/header/FCS output interface. It takes a PSDU request (rate, length), pulls payload bytes from an upstream byte FIFO, computes the IEEE 802.3 CRC-32 on the fly, and appends the 4-byte FCS. It streams the resulting PSDU bytes to the downstream OFDM TX encoder over a valid/ready handshake, and exposes the same state/state_changed debug outputs as the RX core.

---
 rtl/openofdm_tx_psdu_framer.sv | 212 +++++++++++++++++++++
 tb/tb_openofdm_tx_psdu_framer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/openofdm_tx_psdu_framer.sv
// TX PSDU framer: pulls payload bytes, appends the CRC-32 FCS and streams the PSDU to the encoder.
// Optional state history register is built when OPENOFDM_TX_STATE_HISTORY_EN is defined.
module openofdm_tx_psdu_framer #(
  parameter int unsigned UNDERRUN_LIMIT = 1024,
  parameter int unsigned MAX_PKT_LEN    = 4095
) (
  input  logic        s00_axi_aclk,
  input  logic        s00_axi_aresetn,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  pkt_rate_in,
  input  logic [15:0] pkt_len_in,
  input  logic [7:0]  byte_in,
  input  logic        byte_in_valid,
  output logic        byte_in_ready,
  output logic [7:0]  byte_out,
  output logic        byte_out_valid,
  input  logic        byte_out_ready,
  output logic        tx_busy,
  output logic        pkt_header_valid,
  output logic        pkt_header_valid_strobe,
  output logic [7:0]  pkt_rate,
  output logic [15:0] pkt_len,
  output logic [15:0] byte_count,
  output logic        fcs_out_strobe,
  output logic        err_strobe,
  output logic [1:0]  err_code,
  output logic [3:0]  state,
  output logic        state_changed,
  output logic [31:0] state_history
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    HEADER  = 4'd1,
    PAYLOAD = 4'd2,
    FCS     = 4'd3,
    DONE    = 4'd4,
    ERR     = 4'd5
  } state_t;

  localparam int unsigned UW      = $clog2(UNDERRUN_LIMIT + 1);
  localparam logic [15:0] MAX_LEN = 16'(MAX_PKT_LEN);
  localparam logic [UW-1:0] UR_LAST = UW'(UNDERRUN_LIMIT - 1);

  state_t        st;
  logic [31:0]   crc;
  logic [15:0]   taken;
  logic [2:0]    fcs_loaded;
  logic [UW-1:0] ur_cnt;
  logic [15:0]   payload_len;
  logic          free, in_hs, out_hs, last_in, abort_now;
  logic [7:0]    fcs_byte;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int unsigned i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign free          = !byte_out_valid || byte_out_ready;
  assign payload_len   = pkt_len - 16'd4;
  assign byte_in_ready = (st == PAYLOAD) && free && (taken < payload_len);
  assign in_hs         = byte_in_ready && byte_in_valid;
  assign out_hs        = byte_out_valid && byte_out_ready;
  assign last_in       = ((taken + 16'd1) == payload_len);
  assign abort_now     = abort && (st inside {HEADER, PAYLOAD, FCS, DONE});
  assign tx_busy       = (st != IDLE);
  assign state         = st;

  always_comb begin
    fcs_byte = '0;
    case (fcs_loaded[1:0])
      2'd0:    fcs_byte = ~crc[7:0];
      2'd1:    fcs_byte = ~crc[15:8];
      2'd2:    fcs_byte = ~crc[23:16];
      default: fcs_byte = ~crc[31:24];
    endcase
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      st                      <= IDLE;
      crc                     <= '1;
      taken                   <= '0;
      fcs_loaded              <= '0;
      ur_cnt                  <= '0;
      byte_out                <= '0;
      byte_out_valid          <= 1'b0;
      pkt_header_valid        <= 1'b0;
      pkt_header_valid_strobe <= 1'b0;
      pkt_rate                <= '0;
      pkt_len                 <= '0;
      byte_count              <= '0;
      fcs_out_strobe          <= 1'b0;
      err_strobe              <= 1'b0;
      err_code                <= '0;
      state_changed           <= 1'b0;
    end else begin
      pkt_header_valid_strobe <= 1'b0;
      fcs_out_strobe          <= 1'b0;
      err_strobe              <= 1'b0;
      state_changed           <= 1'b0;
      if (out_hs) byte_count <= byte_count + 16'd1;

      if (abort_now) begin
        st             <= ERR;
        err_code       <= 2'd3;
        err_strobe     <= 1'b1;
        byte_out_valid <= 1'b0;
        state_changed  <= 1'b1;
      end else begin
        case (st)
          IDLE: begin
            if (start) begin
              pkt_rate      <= pkt_rate_in;
              pkt_len       <= pkt_len_in;
              byte_count    <= '0;
              err_code      <= '0;
              state_changed <= 1'b1;
              if (pkt_len_in < 16'd5 || pkt_len_in > MAX_LEN) begin
                st         <= ERR;
                err_code   <= 2'd1;
                err_strobe <= 1'b1;
              end else begin
                st                      <= HEADER;
                pkt_header_valid        <= 1'b1;
                pkt_header_valid_strobe <= 1'b1;
              end
            end
          end
          HEADER: begin
            st            <= PAYLOAD;
            state_changed <= 1'b1;
            crc           <= '1;
            taken         <= '0;
            fcs_loaded    <= '0;
            ur_cnt        <= '0;
          end
          PAYLOAD: begin
            if (in_hs) begin
              byte_out       <= byte_in;
              byte_out_valid <= 1'b1;
              crc            <= crc32_byte(crc, byte_in);
              taken          <= taken + 16'd1;
              ur_cnt         <= '0;
              if (last_in) begin
                st            <= FCS;
                state_changed <= 1'b1;
              end
            end else begin
              if (out_hs) byte_out_valid <= 1'b0;
              // Starvation only counts while we are actually willing to take a byte.
              if (byte_in_ready) begin
                if (ur_cnt == UR_LAST) begin
                  st             <= ERR;
                  err_code       <= 2'd2;
                  err_strobe     <= 1'b1;
                  byte_out_valid <= 1'b0;
                  state_changed  <= 1'b1;
                end else begin
                  ur_cnt <= ur_cnt + UW'(1);
                end
              end
            end
          end
          FCS: begin
            if (free && fcs_loaded != 3'd4) begin
              byte_out       <= fcs_byte;
              byte_out_valid <= 1'b1;
              fcs_loaded     <= fcs_loaded + 3'd1;
            end else if (out_hs) begin
              byte_out_valid <= 1'b0;
              if (fcs_loaded == 3'd4) begin
                st             <= DONE;
                fcs_out_strobe <= 1'b1;
                state_changed  <= 1'b1;
              end
            end
          end
          DONE: begin
            st               <= IDLE;
            pkt_header_valid <= 1'b0;
            state_changed    <= 1'b1;
          end
          ERR: begin
            st               <= IDLE;
            pkt_header_valid <= 1'b0;
            byte_out_valid   <= 1'b0;
            state_changed    <= 1'b1;
          end
          default: begin
            st            <= IDLE;
            state_changed <= 1'b1;
          end
        endcase
      end
    end
  end

`ifdef OPENOFDM_TX_STATE_HISTORY_EN
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) state_history <= '0;
    else if (state_changed) state_history <= {state_history[27:0], state};
  end
`else
  assign state_history = '0;
`endif

endmodule

// File: tb/tb_openofdm_tx_psdu_framer.sv
// Directed bench for openofdm_tx_psdu_framer: scoreboarded byte stream plus status checks.
module tb_openofdm_tx_psdu_framer;
  localparam int UL = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0, abort = 1'b0;
  logic [7:0]  pkt_rate_in = '0;
  logic [15:0] pkt_len_in = '0;
  logic [7:0]  byte_in = '0;
  logic        byte_in_valid = 1'b0;
  logic        byte_in_ready;
  logic [7:0]  byte_out;
  logic        byte_out_valid;
  logic        byte_out_ready = 1'b1;
  logic        tx_busy, pkt_header_valid, pkt_header_valid_strobe;
  logic [7:0]  pkt_rate;
  logic [15:0] pkt_len, byte_count;
  logic        fcs_out_strobe, err_strobe;
  logic [1:0]  err_code;
  logic [3:0]  state;
  logic        state_changed;
  logic [31:0] state_history;

  always #5 clk = ~clk;

  openofdm_tx_psdu_framer #(.UNDERRUN_LIMIT(UL), .MAX_PKT_LEN(4095)) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rstn), .start(start), .abort(abort),
    .pkt_rate_in(pkt_rate_in), .pkt_len_in(pkt_len_in),
    .byte_in(byte_in), .byte_in_valid(byte_in_valid), .byte_in_ready(byte_in_ready),
    .byte_out(byte_out), .byte_out_valid(byte_out_valid), .byte_out_ready(byte_out_ready),
    .tx_busy(tx_busy), .pkt_header_valid(pkt_header_valid),
    .pkt_header_valid_strobe(pkt_header_valid_strobe), .pkt_rate(pkt_rate), .pkt_len(pkt_len),
    .byte_count(byte_count), .fcs_out_strobe(fcs_out_strobe), .err_strobe(err_strobe),
    .err_code(err_code), .state(state), .state_changed(state_changed),
    .state_history(state_history)
  );

  int n_vec = 0, n_err = 0;
  int fcs_cnt = 0, err_cnt = 0, hdr_cnt = 0, vld_cnt = 0;
  bit bp_mode = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] pay[$];
  logic [7:0] mon_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      fcs_cnt += int'(fcs_out_strobe);
      err_cnt += int'(err_strobe);
      hdr_cnt += int'(pkt_header_valid_strobe);
      vld_cnt += int'(byte_out_valid);
      if (byte_out_valid && byte_out_ready) begin
        n_vec++;
        assert (exp_q.size() > 0) else begin
          n_err++;
          $error("FAIL unexpected_byte observed=%0h expected=none", byte_out);
        end
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("byte_out", {24'b0, byte_out}, {24'b0, mon_e});
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      byte_out_ready = bp_mode ? ~byte_out_ready : 1'b1;
    end
  end

  function automatic logic [31:0] crc_model(input int n);
    logic [31:0] r;
    r = 32'hFFFFFFFF;
    for (int k = 0; k < n; k++)
      for (int b = 0; b < 8; b++)
        r = (r[0] ^ pay[k][b]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return ~r;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic make_pay(input int n);
    pay.delete();
    for (int k = 0; k < n; k++) pay.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic push_frame(input int n, input bit with_fcs);
    logic [31:0] c;
    for (int k = 0; k < n; k++) exp_q.push_back(pay[k]);
    if (with_fcs) begin
      c = crc_model(pay.size());
      exp_q.push_back(c[7:0]);   exp_q.push_back(c[15:8]);
      exp_q.push_back(c[23:16]); exp_q.push_back(c[31:24]);
    end
  endtask

  task automatic start_frame(input logic [7:0] rate, input logic [15:0] len);
    pkt_rate_in = rate;
    pkt_len_in  = len;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input int n, input int gap_max, input int stall_after,
                      input int stall_len, input bit pulse_start);
    int i, gap, stalled, budget;
    bit hs, v;
    i = 0; gap = 0; stalled = 0; budget = 2000;
    while (i < n && budget > 0) begin
      if (i == stall_after && stalled < stall_len) begin v = 1'b0; stalled++; end
      else if (gap > 0) begin v = 1'b0; gap--; end
      else v = 1'b1;
      byte_in = pay[i];
      byte_in_valid = v;
      if (pulse_start) begin
        start = 1'($urandom_range(0, 1));
        pkt_len_in = 16'd7;
        pkt_rate_in = 8'h99;
      end
      @(negedge clk);
      hs = byte_in_valid && byte_in_ready;
      tick();
      budget--;
      if (hs) begin
        i++;
        if (gap_max > 0) gap = $urandom_range(0, gap_max);
      end
    end
    byte_in_valid = 1'b0;
    start = 1'b0;
    check("feed_budget", {31'b0, budget > 0}, 32'd1);
  endtask

  task automatic wait_idle(input int f0);
    int budget;
    budget = 300;
    while (!(fcs_cnt > f0 && state == 4'd0) && budget > 0) begin
      tick();
      budget--;
    end
    check("done_wait", {31'b0, budget > 0}, 32'd1);
  endtask

  task automatic load_ascii();
    pay.delete();
    for (int k = 0; k < 9; k++) pay.push_back(8'h31 + 8'(k));
  endtask

  task automatic basic_frame(input string tag, input bit bp, input int gap_max);
    int f0, h0;
    f0 = fcs_cnt; h0 = hdr_cnt;
    load_ascii();
    for (int k = 0; k < 9; k++) exp_q.push_back(pay[k]);
    exp_q.push_back(8'h26); exp_q.push_back(8'h39);
    exp_q.push_back(8'hF4); exp_q.push_back(8'hCB);
    bp_mode = bp;
    start_frame(8'h0B, 16'd13);
    feed(9, gap_max, -1, 0, 1'b0);
    wait_idle(f0);
    bp_mode = 1'b0;
    tick(); tick();
    check({tag, "_fcs_strobes"}, fcs_cnt - f0, 32'd1);
    check({tag, "_hdr_strobes"}, hdr_cnt - h0, 32'd1);
    check({tag, "_byte_count"}, {16'b0, byte_count}, 32'd13);
    check({tag, "_err_code"}, {30'b0, err_code}, 32'd0);
    check({tag, "_queue_empty"}, exp_q.size(), 32'd0);
    check({tag, "_hdr_valid_low"}, {31'b0, pkt_header_valid}, 32'd0);
    check({tag, "_pkt_len"}, {16'b0, pkt_len}, 32'd13);
    check({tag, "_pkt_rate"}, {24'b0, pkt_rate}, 32'h0B);
  endtask

  initial begin
    int f0, h0, v0, e0, k, budget;

    // Reset state
    rstn = 1'b0;
    tick(); tick(); tick();
    check("rst_state", {28'b0, state}, 32'd0);
    check("rst_outs", {31'b0, |{byte_in_ready, byte_out, byte_out_valid, tx_busy, pkt_header_valid,
          pkt_header_valid_strobe, pkt_rate, pkt_len, byte_count, fcs_out_strobe, err_strobe,
          err_code, state_changed}}, 32'd0);
    check("rst_history", state_history, 32'd0);
    rstn = 1'b1;
    tick();

    // Basic frame: "123456789"
    basic_frame("basic", 1'b0, 0);
`ifdef OPENOFDM_TX_STATE_HISTORY_EN
    check("history", state_history, 32'h00012340);
`else
    check("history_tied", state_history, 32'd0);
`endif

    // Backpressure with random input gaps
    basic_frame("bp", 1'b1, 3);

    // Length checks
    h0 = hdr_cnt; v0 = vld_cnt; e0 = err_cnt;
    start_frame(8'h0B, 16'd4);
    check("len4_state", {28'b0, state}, 32'd5);
    check("len4_code", {30'b0, err_code}, 32'd1);
    tick(); tick();
    start_frame(8'h0B, 16'd4096);
    check("len4096_state", {28'b0, state}, 32'd5);
    check("len4096_code", {30'b0, err_code}, 32'd1);
    tick(); tick();
    check("len_err_strobes", err_cnt - e0, 32'd2);
    check("len_no_hdr", hdr_cnt - h0, 32'd0);
    check("len_no_valid", vld_cnt - v0, 32'd0);

    // Minimum length: single payload byte
    f0 = fcs_cnt;
    make_pay(1);
    push_frame(1, 1'b1);
    start_frame(8'h0D, 16'd5);
    feed(1, 0, -1, 0, 1'b0);
    wait_idle(f0);
    tick();
    check("len5_byte_count", {16'b0, byte_count}, 32'd5);
    check("len5_queue_empty", exp_q.size(), 32'd0);

    // Underrun: 16 starved cycles abort the frame
    make_pay(16);
    push_frame(3, 1'b0);
    start_frame(8'h0B, 16'd20);
    feed(3, 0, -1, 0, 1'b0);
    k = 0;
    while (err_code != 2'd2 && k < 40) begin
      tick();
      k++;
    end
    check("underrun_latency", k, 32'd16);
    check("underrun_strobe", {31'b0, err_strobe}, 32'd1);
    check("underrun_valid", {31'b0, byte_out_valid}, 32'd0);
    tick(); tick();
    check("underrun_queue", exp_q.size(), 32'd0);

    // 15-cycle gap is tolerated
    f0 = fcs_cnt;
    make_pay(16);
    push_frame(16, 1'b1);
    start_frame(8'h0B, 16'd20);
    feed(16, 0, 3, 15, 1'b0);
    wait_idle(f0);
    tick();
    check("gap15_err_code", {30'b0, err_code}, 32'd0);
    check("gap15_byte_count", {16'b0, byte_count}, 32'd20);
    check("gap15_queue", exp_q.size(), 32'd0);

    // Abort during the 5th payload byte
    f0 = fcs_cnt;
    make_pay(16);
    push_frame(5, 1'b0);
    start_frame(8'h0B, 16'd20);
    feed(5, 0, -1, 0, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_state", {28'b0, state}, 32'd5);
    check("abort_code", {30'b0, err_code}, 32'd3);
    check("abort_valid", {31'b0, byte_out_valid}, 32'd0);
    check("abort_strobe", {31'b0, err_strobe}, 32'd1);
    check("abort_byte_count", {16'b0, byte_count}, 32'd5);
    tick(); tick();
    check("abort_idle", {28'b0, state}, 32'd0);
    check("abort_no_fcs", fcs_cnt - f0, 32'd0);
    check("abort_queue", exp_q.size(), 32'd0);

    // Reset during the FCS bytes
    make_pay(9);
    push_frame(9, 1'b1);
    start_frame(8'h0B, 16'd13);
    feed(9, 0, -1, 0, 1'b0);
    budget = 50;
    while (state != 4'd3 && budget > 0) begin tick(); budget--; end
    check("fcs_reach", {31'b0, budget > 0}, 32'd1);
    tick(); tick();
    rstn = 1'b0;
    tick();
    check("midfcs_rst_outs", {31'b0, |{byte_in_ready, byte_out, byte_out_valid, tx_busy,
          pkt_header_valid, pkt_header_valid_strobe, pkt_rate, pkt_len, byte_count,
          fcs_out_strobe, err_strobe, err_code, state, state_changed}}, 32'd0);
    check("midfcs_rst_history", state_history, 32'd0);
    rstn = 1'b1;
    exp_q.delete();
    tick();
    check("post_rst_idle_valid", {31'b0, byte_out_valid}, 32'd0);

    // Frame after reset
    basic_frame("post_rst", 1'b0, 0);

    // start pulses during PAYLOAD are ignored
    f0 = fcs_cnt;
    make_pay(9);
    push_frame(9, 1'b1);
    start_frame(8'h0B, 16'd13);
    feed(9, 1, -1, 0, 1'b1);
    wait_idle(f0);
    tick();
    check("restart_pkt_len", {16'b0, pkt_len}, 32'd13);
    check("restart_pkt_rate", {24'b0, pkt_rate}, 32'h0B);
    check("restart_byte_count", {16'b0, byte_count}, 32'd13);
    check("restart_queue", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
